knn_ctrl: RTL

Sequencing controller for the k-NN classification datapath. On `start` it pulses the top-5 selector's reset and streams `N_SAMPLES` training-memory addresses. It tracks the memory and distance-unit latency so that the selector's `valid` lines up with each distance result. When the selector has settled, it takes a majority vote over the five nearest-neighbour class bits and reports the result with a one-cycle `done` pulse.

---
 rtl/knn_ctrl_if.sv | 54 +++++
 rtl/knn_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/knn_ctrl_if.sv
// Handshake bundle between the k-NN sequencing controller and its datapath:
// start/done, training-memory read port, top-5 selector controls and vote result.
interface knn_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              ksel_rst_n;
    logic              sel_valid;
    logic              class1;
    logic              class2;
    logic              class3;
    logic              class4;
    logic              class5;
    logic              class_out;
    logic [2:0]        vote_cnt;

    modport master (
        input  start,
        input  class1,
        input  class2,
        input  class3,
        input  class4,
        input  class5,
        output busy,
        output done,
        output mem_rd_en,
        output mem_addr,
        output ksel_rst_n,
        output sel_valid,
        output class_out,
        output vote_cnt
    );

    modport slave (
        output start,
        output class1,
        output class2,
        output class3,
        output class4,
        output class5,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_addr,
        input  ksel_rst_n,
        input  sel_valid,
        input  class_out,
        input  vote_cnt
    );
endinterface

// File: rtl/knn_ctrl.sv
// Sequences one k-NN classification: clear the top-5 selector, stream training addresses,
// align selector valid with the distance pipeline, then majority-vote the five neighbours.
module knn_ctrl #(
    parameter int unsigned N_SAMPLES = 64,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned DIST_LAT  = 2
) (
    input logic        clk,
    input logic        reset,
    knn_ctrl_if.master bus
);
    localparam int unsigned DrainW = (DIST_LAT > 0) ? $clog2(DIST_LAT + 1) : 1;
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(DIST_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StDrain,
        StVote,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [DIST_LAT:0] vpipe_q, vpipe_d;
    logic [2:0]        vote_q, vote_d;
    logic              class_q, class_d;
    logic              busy_q, done_q, rd_en_q, ksel_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        vote_d  = vote_q;
        class_d = class_q;

        // Stage 0 follows the read strobe; the last stage lines up with the distance result.
        vpipe_d[0] = rd_en_q;
        for (int k = 1; k <= DIST_LAT; k++) begin
            vpipe_d[k] = vpipe_q[k-1];
        end

        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StClear;
            end
            StClear: begin
                addr_d  = '0;
                state_d = StIssue;
            end
            StIssue: begin
                drain_d = '0;
                // Terminal compare on the count itself so a full 2^ADDR_W sweep never wraps.
                if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    state_d = StVote;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StVote: begin
                vote_d  = 3'(bus.class1) + 3'(bus.class2) + 3'(bus.class3)
                        + 3'(bus.class4) + 3'(bus.class5);
                class_d = (vote_d >= 3'd3);
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            drain_q <= '0;
            vpipe_q <= '0;
            vote_q  <= '0;
            class_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            ksel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            vpipe_q <= vpipe_d;
            vote_q  <= vote_d;
            class_q <= class_d;
            // Output flops decode the next state so every output is a plain register.
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            rd_en_q <= (state_d == StIssue);
            ksel_q  <= (state_d != StClear);
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.mem_addr   = addr_q;
    assign bus.ksel_rst_n = ksel_q;
    assign bus.sel_valid  = vpipe_q[DIST_LAT];
    assign bus.class_out  = class_q;
    assign bus.vote_cnt   = vote_q;
endmodule
